alu_op_sequencer: RTL and testbench

Sequencing controller that wraps the combinational 32-bit ALU and owns the Z (HI:LO) result register. It accepts one operation per start/done handshake. Single-cycle ops are issued to the external ALU through its A/B/op/result ports. MUL and DIV run internally as 32-iteration signed shift-add and restoring-divide sequences. The block sits between the control unit and the datapath Z register inputs.

---
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Operation request/result bundle between the control unit, the sequencer and the external ALU.
interface alu_op_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      start;
   logic [3:0]                op_in;
   logic [DATA_WIDTH-1:0]     a_in;
   logic [DATA_WIDTH-1:0]     b_in;
   logic [DATA_WIDTH-1:0]     alu_a;
   logic [DATA_WIDTH-1:0]     alu_b;
   logic [3:0]                alu_op;
   logic [2*DATA_WIDTH-1:0]   alu_result;
   logic                      busy;
   logic                      done;
   logic [DATA_WIDTH-1:0]     z_hi;
   logic [DATA_WIDTH-1:0]     z_lo;
   logic                      div_zero;

   // master: control unit plus combinational ALU; slave: the sequencer
   modport master (
      output start, op_in, a_in, b_in, alu_result,
      input  alu_a, alu_b, alu_op, busy, done, z_hi, z_lo, div_zero
   );
   modport slave (
      input  start, op_in, a_in, b_in, alu_result,
      output alu_a, alu_b, alu_op, busy, done, z_hi, z_lo, div_zero
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Start/done sequencer around the combinational ALU that owns the Z (HI:LO) register.
// Single-cycle ops use the external ALU; MUL/DIV run 32 signed shift-add / restoring-divide steps.
module alu_op_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic              clock,
   input  logic              clear,
   alu_op_sequencer_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [3:0] OP_AND = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_DIV = 4'd13;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_FIX, S_DONE} state_t;
   state_t state, state_nxt;

   logic [3:0]     op_q;
   logic [W-1:0]   a_q, b_q;
   logic           sign_a, sign_b;
   logic [W-1:0]   mag;        // |A| for MUL, |B| for DIV
   logic [2*W-1:0] acc;        // MUL: {hi, lo=multiplier}; DIV: {remainder, quotient}
   logic [CW-1:0]  count;
   logic [W-1:0]   z_hi, z_lo;
   logic           div_zero;

   logic [W-1:0]   abs_a, abs_b;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_shift;
   logic           div_ok;
   logic [W-1:0]   rem_sub;
   logic [2*W-1:0] div_next;
   logic [W-1:0]   quo_fix, rem_fix;

   assign abs_a = bus.a_in[W-1] ? -bus.a_in : bus.a_in;
   assign abs_b = bus.b_in[W-1] ? -bus.b_in : bus.b_in;

   assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag} : {(W+1){1'b0}});
   assign mul_next = {mul_sum, acc[W-1:1]};

   assign div_shift = {acc[2*W-1:W], acc[W-1]};
   assign div_ok    = (div_shift >= {1'b0, mag});
   assign rem_sub   = div_shift[W-1:0] - mag;
   assign div_next  = div_ok ? {rem_sub, acc[W-2:0], 1'b1}
                             : {div_shift[W-1:0], acc[W-2:0], 1'b0};

   assign quo_fix = (sign_a != sign_b) ? -acc[W-1:0] : acc[W-1:0];
   assign rem_fix = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];

   always_ff @(posedge clock or posedge clear) begin
      if (clear) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.op_in == OP_DIV && bus.b_in == '0)
                  state_nxt = S_FIX;
               else if (bus.op_in == OP_MUL || bus.op_in == OP_DIV)
                  state_nxt = S_ITER;
               else
                  state_nxt = S_EXEC;
            end
         end
         S_EXEC:  state_nxt = S_DONE;
         S_ITER:  if (count == CW'(W-1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != S_IDLE);
      bus.done = (state == S_DONE);
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         mag      <= '0;
         acc      <= '0;
         count    <= '0;
         z_hi     <= '0;
         z_lo     <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q     <= (bus.op_in >= 4'd14) ? OP_AND : bus.op_in;
                  a_q      <= bus.a_in;
                  b_q      <= bus.b_in;
                  sign_a   <= bus.a_in[W-1];
                  sign_b   <= bus.b_in[W-1];
                  count    <= '0;
                  div_zero <= 1'b0;
                  if (bus.op_in == OP_MUL) begin
                     mag <= abs_a;
                     acc <= {{W{1'b0}}, abs_b};
                  end else begin
                     mag <= abs_b;
                     acc <= {{W{1'b0}}, abs_a};
                  end
               end
            end
            S_EXEC: {z_hi, z_lo} <= bus.alu_result;
            S_ITER: begin
               acc   <= (op_q == OP_MUL) ? mul_next : div_next;
               count <= count + 1'b1;
            end
            S_FIX: begin
               if (op_q == OP_MUL) begin
                  {z_hi, z_lo} <= (sign_a != sign_b) ? -acc : acc;
               end else if (b_q == '0) begin
                  z_lo     <= '1;
                  z_hi     <= a_q;
                  div_zero <= 1'b1;
               end else begin
                  z_lo <= quo_fix;
                  z_hi <= rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_a    = a_q;
   assign bus.alu_b    = b_q;
   assign bus.alu_op   = op_q;
   assign bus.z_hi     = z_hi;
   assign bus.z_lo     = z_lo;
   assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the combinational ALU attached.
module tb_alu_op_sequencer;
   logic clock = 1'b0;
   logic clear;
   int   total = 0;
   int   bad   = 0;

   alu_op_sequencer_if #(.DATA_WIDTH(32)) bif ();

   alu_op_sequencer #(.DATA_WIDTH(32)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bif)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      logic [4:0]  s;
      s = b[4:0];
      case (op)
         4'd0:    r = a | b;
         4'd2:    r = a + b;
         4'd3:    r = a - b;
         4'd4:    r = a ^ b;
         4'd5:    r = a >> s;
         4'd6:    r = $signed(a) >>> s;
         4'd7:    r = a << s;
         4'd8:    r = (a >> s) | (a << (6'd32 - {1'b0, s}));
         4'd9:    r = (a << s) | (a >> (6'd32 - {1'b0, s}));
         4'd10:   r = -a;
         4'd11:   r = ~a;
         default: r = a & b;
      endcase
      return {32'h0, r};
   endfunction

   assign bif.alu_result = alu_model(bif.alu_op, bif.alu_a, bif.alu_b);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one op, waits (bounded) for done, checks latency and Z, then returns to IDLE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat;
      bif.start = 1'b1;
      bif.op_in = op;
      bif.a_in  = a;
      bif.b_in  = b;
      tick();
      bif.start = 1'b0;
      lat = 1;
      while (bif.done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_z"}, {bif.z_hi, bif.z_lo}, {exp_hi, exp_lo});
      tick();
   endtask

   initial begin
      int  dones;
      bit  saw_done;

      clear      = 1'b1;
      bif.start  = 1'b0;
      bif.op_in  = 4'd0;
      bif.a_in   = 32'h0;
      bif.b_in   = 32'h0;
      tick();
      tick();
      check("rst_busy", 64'(bif.busy), 64'd0);
      check("rst_done", 64'(bif.done), 64'd0);
      check("rst_z", {bif.z_hi, bif.z_lo}, 64'd0);
      check("rst_alu_ab", {bif.alu_a, bif.alu_b}, 64'd0);
      check("rst_alu_op", 64'(bif.alu_op), 64'd0);
      check("rst_div_zero", 64'(bif.div_zero), 64'd0);
      clear = 1'b0;
      tick();

      // ADD overflow with per-cycle checks
      bif.start = 1'b1;
      bif.op_in = 4'd2;
      bif.a_in  = 32'h7FFF_FFFF;
      bif.b_in  = 32'h0000_0001;
      tick();
      bif.start = 1'b0;
      check("add_c1_busy", 64'(bif.busy), 64'd1);
      check("add_c1_done", 64'(bif.done), 64'd0);
      check("add_c1_alu_op", 64'(bif.alu_op), 64'd2);
      tick();
      check("add_c2_done", 64'(bif.done), 64'd1);
      check("add_c2_busy", 64'(bif.busy), 64'd1);
      check("add_c2_z_lo", 64'(bif.z_lo), 64'h8000_0000);
      tick();
      check("add_c3_busy", 64'(bif.busy), 64'd0);
      check("add_c3_done", 64'(bif.done), 64'd0);

      run_op("sub", 4'd3, 32'd5, 32'd7, 2, 32'h0, 32'hFFFF_FFFE);
      run_op("xor", 4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 2, 32'h0, 32'hFF00_EDCB);
      run_op("shra", 4'd6, 32'h8000_0000, 32'd4, 2, 32'h0, 32'hF800_0000);
      run_op("rol", 4'd9, 32'h8000_0001, 32'd1, 2, 32'h0, 32'h0000_0003);
      run_op("op15_and", 4'd15, 32'hFF00_FF00, 32'h0F0F_0F0F, 2, 32'h0, 32'h0F00_0F00);

      run_op("mul_m3x7", 4'd12, 32'hFFFF_FFFD, 32'd7, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mul_m1xm1", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0, 32'h1);
      run_op("mul_minxmin", 4'd12, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0);
      run_op("mul_minx1", 4'd12, 32'h8000_0000, 32'd1, 34, 32'hFFFF_FFFF, 32'h8000_0000);

      run_op("div_m17d5", 4'd13, 32'hFFFF_FFEF, 32'd5, 34, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_op("div_17dm5", 4'd13, 32'd17, 32'hFFFF_FFFB, 34, 32'h0000_0002, 32'hFFFF_FFFD);
      run_op("div_mindm1", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
      check("div_mindm1_flag", 64'(bif.div_zero), 64'd0);

      run_op("div_42d0", 4'd13, 32'd42, 32'd0, 2, 32'd42, 32'hFFFF_FFFF);
      check("div0_flag", 64'(bif.div_zero), 64'd1);
      bif.start = 1'b1;
      bif.op_in = 4'd2;
      bif.a_in  = 32'd1;
      bif.b_in  = 32'd1;
      tick();
      bif.start = 1'b0;
      check("div0_flag_cleared", 64'(bif.div_zero), 64'd0);
      tick();
      check("after_div0_add", {bif.z_hi, bif.z_lo}, 64'd2);
      tick();

      // start held high: one single-cycle op every 3 cycles
      bif.start = 1'b1;
      bif.op_in = 4'd0;
      bif.a_in  = 32'h0000_00F0;
      bif.b_in  = 32'h0000_000F;
      dones = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (bif.done === 1'b1) dones++;
      end
      bif.start = 1'b0;
      tick();
      if (bif.done === 1'b1) dones++;
      check("held_start_dones", 64'(dones), 64'd3);
      check("held_start_idle", 64'(bif.busy), 64'd0);
      check("held_start_z", 64'(bif.z_lo), 64'h0000_00FF);

      // MUL, ignored start at cycle 10, clear at cycle 20
      saw_done  = 1'b0;
      bif.start = 1'b1;
      bif.op_in = 4'd12;
      bif.a_in  = 32'd5;
      bif.b_in  = 32'd6;
      tick();
      bif.start = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         tick();
         if (bif.done === 1'b1) saw_done = 1'b1;
      end
      bif.start = 1'b1;
      bif.op_in = 4'd2;
      bif.a_in  = 32'd1;
      bif.b_in  = 32'd1;
      tick();
      bif.start = 1'b0;
      check("ignored_start_busy", 64'(bif.busy), 64'd1);
      check("ignored_start_op", 64'(bif.alu_op), 64'd12);
      for (int c = 12; c <= 20; c++) begin
         tick();
         if (bif.done === 1'b1) saw_done = 1'b1;
      end
      clear = 1'b1;
      #1;
      check("abort_busy", 64'(bif.busy), 64'd0);
      check("abort_z", {bif.z_hi, bif.z_lo}, 64'd0);
      check("abort_alu_op", 64'(bif.alu_op), 64'd0);
      tick();
      clear = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bif.done === 1'b1) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);
      run_op("post_abort_add", 4'd2, 32'd3, 32'd4, 2, 32'h0, 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
